// File: rtl/jt51_wrseq_pkg.sv
// Shared definitions for the JT51 register write sequencer.
package jt51_wrseq_pkg;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_GAP  = 3'd2,
    ST_DATA = 3'd3,
    ST_HOLD = 3'd4,
    ST_WAIT = 3'd5
  } state_t;

  // Cycles after a data write during which busy is not yet trustworthy
  localparam int HOLD_CYC = 2;

endpackage

// File: rtl/jt51_wrseq_fifo.sv
// Circular FIFO holding {addr,data} pairs. The head entry is read
// combinationally so the sequencer can pop and drive it in the same cycle.
module jt51_wrseq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             push_ok, pop_ok;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A push into a full queue is fine when the head leaves in the same cycle
  assign push_ok = push & (~full | pop_ok);
  assign level   = level_reg;
  assign dout    = mem[rd_ptr_reg];

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok)      level_reg <= level_reg + 1'b1;
      else if (pop_ok && !push_ok) level_reg <= level_reg - 1'b1;
    end
  end

  // Storage needs no reset; stale entries are never read past level
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/jt51_wrseq.sv
// Replays queued register/value pairs onto the JT51 CPU port as an address
// write followed by a data write, pacing pairs on the core's busy flag.
module jt51_wrseq
  import jt51_wrseq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit SKIP_ADDR = 1'b1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_data,
  output logic [7:0]  dout,
  output logic        write,
  output logic        a0,
  input  logic        busy,
  output logic        idle,
  output logic [AW:0] level
);

  state_t      state_reg;
  logic [7:0]  cur_data_reg;
  logic [7:0]  last_addr_reg;
  logic        last_valid_reg;
  logic [1:0]  hold_cnt_reg;
  logic [7:0]  dout_reg;
  logic        write_reg, a0_reg;

  logic [15:0] head;
  logic        fifo_full, fifo_empty;
  logic        fetch, skip_hit;

  jt51_wrseq_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid & req_ready),
    .pop   (fetch),
    .din   ({req_addr, req_data}),
    .dout  (head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // WAIT with busy low may fetch directly so pairs can run back to back
  assign fetch     = !fifo_empty &&
                     ((state_reg == ST_IDLE) || (state_reg == ST_WAIT && !busy));
  assign skip_hit  = SKIP_ADDR && last_valid_reg && (head[15:8] == last_addr_reg);
  assign req_ready = !fifo_full;
  assign idle      = (state_reg == ST_IDLE) && fifo_empty;
  assign dout      = dout_reg;
  assign write     = write_reg;
  assign a0        = a0_reg;

  // Sequencer FSM; outputs are registered with the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cur_data_reg   <= '0;
      last_addr_reg  <= '0;
      last_valid_reg <= 1'b0;
      hold_cnt_reg   <= '0;
      dout_reg       <= '0;
      write_reg      <= 1'b0;
      a0_reg         <= 1'b1;
    end else begin
      write_reg <= 1'b0;
      a0_reg    <= 1'b1;
      case (state_reg)
        ST_IDLE, ST_WAIT: begin
          if (fetch) begin
            cur_data_reg <= head[7:0];
            write_reg    <= 1'b1;
            if (skip_hit) begin
              state_reg <= ST_DATA;
              dout_reg  <= head[7:0];
            end else begin
              state_reg      <= ST_ADDR;
              a0_reg         <= 1'b0;
              dout_reg       <= head[15:8];
              last_addr_reg  <= head[15:8];
              last_valid_reg <= 1'b1;
            end
          end else if (!busy) begin
            state_reg <= ST_IDLE;
          end
        end
        // Write low for one cycle so the core sees a fresh rising edge
        ST_ADDR: state_reg <= ST_GAP;
        ST_GAP: begin
          state_reg <= ST_DATA;
          write_reg <= 1'b1;
          dout_reg  <= cur_data_reg;
        end
        ST_DATA: begin
          state_reg    <= ST_HOLD;
          hold_cnt_reg <= 2'(HOLD_CYC - 1);
        end
        // Busy from the core is still stale here, so it is ignored
        ST_HOLD: begin
          if (hold_cnt_reg == '0) state_reg <= ST_WAIT;
          else                    hold_cnt_reg <= hold_cnt_reg - 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt51_wrseq.sv
// Directed bench for jt51_wrseq: one instance with address skipping, one
// without, each with its own 32-cycle busy model.
module tb_jt51_wrseq;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b1;
  logic [7:0] req_addr = 8'hAA;
  logic [7:0] req_data = 8'h55;
  logic busy_force = 1'b0;
  logic stuck_low = 1'b0;

  logic rdy0, rdy1, wr0, wr1, a0_0, a0_1, idle0, idle1, busy0, busy1;
  logic [7:0] dout0, dout1;
  logic [LW-1:0] lvl0, lvl1;

  int bc0 = 0, bc1 = 0;
  int cyc = 0;
  int checks = 0, errors = 0;
  logic [8:0] wl0[$], wl1[$];
  int wc0[$], wc1[$];

  always #5 clk = ~clk;

  jt51_wrseq #(.DEPTH(DEPTH), .SKIP_ADDR(1'b1)) u_skip (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0),
    .req_addr(req_addr), .req_data(req_data), .dout(dout0), .write(wr0),
    .a0(a0_0), .busy(busy0), .idle(idle0), .level(lvl0)
  );

  jt51_wrseq #(.DEPTH(DEPTH), .SKIP_ADDR(1'b0)) u_noskip (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
    .req_addr(req_addr), .req_data(req_data), .dout(dout1), .write(wr1),
    .a0(a0_1), .busy(busy1), .idle(idle1), .level(lvl1)
  );

  assign busy0 = !stuck_low && (busy_force || bc0 != 0);
  assign busy1 = !stuck_low && (busy_force || bc1 != 0);

  always @(posedge clk) cyc <= cyc + 1;

  // Core busy model: 32 cycles starting the edge after a data write
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc0 <= 0;
      bc1 <= 0;
    end else begin
      if (wr0 && a0_0) bc0 <= 32; else if (bc0 != 0) bc0 <= bc0 - 1;
      if (wr1 && a0_1) bc1 <= 32; else if (bc1 != 0) bc1 <= bc1 - 1;
    end
  end

  // Write-port monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr0) begin
        wl0.push_back({a0_0, dout0});
        wc0.push_back(cyc);
        $display("write skip   a0=%0d dout=%02h cyc=%0d", a0_0, dout0, cyc);
      end
      if (wr1) begin
        wl1.push_back({a0_1, dout1});
        wc1.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    wl0.delete(); wl1.delete(); wc0.delete(); wc1.delete();
    rst_n = 1'b1;
  endtask

  task automatic push_try(input logic [7:0] a, input logic [7:0] d,
                          output bit ok, output int pcyc);
    @(negedge clk);
    req_addr = a;
    req_data = d;
    req_valid = 1'b1;
    ok = rdy0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    pcyc = cyc;
    $display("push addr=%02h data=%02h accepted=%0d cyc=%0d", a, d, ok, pcyc);
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] d, output int pcyc);
    bit ok;
    ok = 1'b0;
    pcyc = 0;
    for (int t = 0; t < 200 && !ok; t++) push_try(a, d, ok, pcyc);
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int maxc, output int at_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(idle0 && idle1) && n < maxc);
    at_cyc = cyc;
    chk("idle_timeout", 32'(idle0 && idle1), 1);
  endtask

  initial begin
    int pc, ic, acc, dummy;
    bit ok;

    // Reset with a request pending
    repeat (3) @(negedge clk);
    chk("rst_write", 32'(wr0), 0);
    chk("rst_a0", 32'(a0_0), 1);
    chk("rst_dout", 32'(dout0), 0);
    chk("rst_level", 32'(lvl0), 0);
    chk("rst_ready", 32'(rdy0), 1);
    chk("rst_idle", 32'(idle0), 1);
    apply_reset();

    // Single pair with busy
    push_pair(8'h20, 8'hC7, pc);
    wait_idle(200, ic);
    chk("single_cnt", wl0.size(), 2);
    chk("single_addr", 32'(wl0[0]), 32'h020);
    chk("single_data", 32'(wl0[1]), 32'h1C7);
    chk("single_lat", wc0[0] - pc, 1);
    chk("single_gap", wc0[1] - wc0[0], 2);
    chk("single_idle_cyc", ic - pc, 37);
    chk("single_dout_hold", 32'(dout0), 32'hC7);
    chk("single_a0_idle", 32'(a0_0), 1);

    // Address skip on repeated address
    apply_reset();
    push_pair(8'h08, 8'h78, dummy);
    push_pair(8'h08, 8'h00, dummy);
    wait_idle(400, ic);
    chk("skip_cnt", wl0.size(), 3);
    chk("skip_first_addr", 32'(wl0[0]), 32'h008);
    chk("skip_second", 32'(wl0[2]), 32'h100);
    chk("noskip_cnt", wl1.size(), 4);
    chk("noskip_addr2", 32'(wl1[2]), 32'h008);
    chk("noskip_data2", 32'(wl1[3]), 32'h100);

    // Full queue while busy is stuck high
    apply_reset();
    busy_force = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      push_try(8'h40 + 8'(i), 8'h90 + 8'(i), ok, dummy);
      if (ok) acc++;
    end
    chk("full_accepts", acc, 9);
    chk("full_ready", 32'(rdy0), 0);
    chk("full_level", 32'(lvl0), 8);
    busy_force = 1'b0;
    wait_idle(1000, ic);
    chk("full_cnt", wl0.size(), 18);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("full_addr%0d", i), 32'(wl0[2*i]), 32'h040 + i);
      chk($sformatf("full_data%0d", i), 32'(wl0[2*i+1]), 32'h190 + i);
    end

    // Busy tied low: data writes 6 clocks apart
    apply_reset();
    stuck_low = 1'b1;
    push_pair(8'h50, 8'hA1, dummy);
    push_pair(8'h51, 8'hA2, dummy);
    push_pair(8'h52, 8'hA3, dummy);
    wait_idle(200, ic);
    chk("stuck_cnt", wl0.size(), 6);
    chk("stuck_space1", wc0[3] - wc0[1], 6);
    chk("stuck_space2", wc0[5] - wc0[3], 6);
    chk("stuck_data3", 32'(wl0[5]), 32'h1A3);
    stuck_low = 1'b0;

    // Reset in GAP, then a fresh pair to the same address
    apply_reset();
    push_pair(8'h30, 8'h55, dummy);
    push_pair(8'h31, 8'h66, dummy);
    push_pair(8'h32, 8'h77, dummy);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      #2;
      if (wl0.size() == 1 && !wr0) ok = 1'b1;
    end
    chk("gap_found", 32'(ok), 1);
    chk("gap_level_before", 32'(lvl0), 2);
    rst_n = 1'b0;
    #1;
    chk("gap_rst_write", 32'(wr0), 0);
    chk("gap_rst_level", 32'(lvl0), 0);
    chk("gap_rst_idle", 32'(idle0), 1);
    apply_reset();
    push_pair(8'h30, 8'h99, dummy);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      #2;
      if (wr0 && a0_0) ok = 1'b1;
    end
    chk("post_data_found", 32'(ok), 1);
    chk("post_cnt", wl0.size(), 2);
    chk("post_addr", 32'(wl0[0]), 32'h030);
    // Reset during the data strobe drops write without a clock edge
    rst_n = 1'b0;
    #1;
    chk("data_rst_write", 32'(wr0), 0);
    chk("data_rst_a0", 32'(a0_0), 1);
    apply_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
